// File: rtl/mem_rd_pkg.sv
// mem_rd_pkg: shared constants, state encoding and credit helper for the
// frame read-out stage (mem_rd_stream) and its elastic FIFO (mem_rd_fifo).
package mem_rd_pkg;

  // Cycles from the BRAM sampling an address to its word appearing on i_rdata
  localparam int BRAM_RD_LATENCY = 2;
  // Elastic buffer depth; also the total credit pool for outstanding reads
  localparam int RD_FIFO_DEPTH   = 8;
  localparam int RD_FIFO_CW      = $clog2(RD_FIFO_DEPTH + 1);
  localparam int INFLIGHT_W      = $clog2(BRAM_RD_LATENCY + 1);

  localparam logic [RD_FIFO_CW:0] RD_FIFO_LIMIT = (RD_FIFO_CW + 1)'(RD_FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  // A new read may be issued only while every outstanding word still has a
  // guaranteed FIFO slot, so returning BRAM data can never be dropped.
  function automatic logic credit_ok(input logic [RD_FIFO_CW-1:0] count,
                                     input logic [INFLIGHT_W-1:0] inflight);
    logic [RD_FIFO_CW:0] total;
    total = {1'b0, count} + {{(RD_FIFO_CW + 1 - INFLIGHT_W){1'b0}}, inflight};
    return (total < RD_FIFO_LIMIT);
  endfunction

endpackage

// File: rtl/mem_rd_fifo.sv
// mem_rd_fifo: first-word-fall-through synchronous FIFO with occupancy count.
// Head word is always visible on o_rdata; pops while empty are ignored.
// Writers must respect the count (no overflow protection inside).
module mem_rd_fifo
  import mem_rd_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int DEPTH = RD_FIFO_DEPTH
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             pop_s;

  assign pop_s   = i_pop && (count_r != '0);
  assign o_rdata = mem_r[rd_ptr_r];
  assign o_empty = (count_r == '0);
  assign o_count = count_r;

  // Storage: cleared on reset so the head reads as zero until first write
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (i_push) begin
      mem_r[wr_ptr_r] <= i_wdata;
    end
  end

  // Pointers and occupancy; push and pop together leave the count unchanged
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (i_push) begin
        wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? '0 : wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? '0 : rd_ptr_r + PW'(1);
      end
      case ({i_push, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mem_rd_stream.sv
// mem_rd_stream: sweeps a frame BRAM from address 0 to DEPTH-1 on i_start,
// tracks the BRAM read latency with a valid shift register and delivers the
// words as a valid/ready stream with sof/eof markers through a credit-limited
// elastic FIFO.
// Optional feature macro: MEM_RD_EOL_EN adds o_eol (last pixel of each line).
module mem_rd_stream
  import mem_rd_pkg::*;
#(
  parameter int DATA_WIDTH  = 12,
  parameter int DEPTH       = 16384,
  parameter int LINE_PIXELS = 128
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [$clog2(DEPTH)-1:0]  o_raddr,
  input  logic [DATA_WIDTH-1:0]     i_rdata,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_sof,
  output logic                      o_eof
`ifdef MEM_RD_EOL_EN
  ,
  output logic                      o_eol
`endif
);

  localparam int AW     = $clog2(DEPTH);
  localparam int SB_SOF = 0;
  localparam int SB_EOF = 1;
`ifdef MEM_RD_EOL_EN
  localparam int SB_EOL = 2;
  localparam int SB_W   = 3;
  localparam int LW     = $clog2(LINE_PIXELS);
  localparam logic [LW-1:0] LAST_COL = LW'(LINE_PIXELS - 1);
`else
  localparam int SB_W   = 2;
`endif
  localparam int FW     = DATA_WIDTH + SB_W;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  // Elaboration-time sanity checks on the frame geometry
  if (LINE_PIXELS < 1) begin : g_bad_line_pixels
    $error("mem_rd_stream: LINE_PIXELS must be positive");
  end
`ifdef MEM_RD_EOL_EN
  if ((LINE_PIXELS < 2) || ((DEPTH % LINE_PIXELS) != 0)) begin : g_bad_line_geom
    $error("mem_rd_stream: DEPTH must be a multiple of LINE_PIXELS (>= 2)");
  end
`endif

  rd_state_t                  state_r;
  logic [AW-1:0]              raddr_r;
  logic                       busy_r;
  logic                       done_r;
  logic [BRAM_RD_LATENCY-1:0] v_r;
  logic [SB_W-1:0]            sb_r [BRAM_RD_LATENCY];
  logic [SB_W-1:0]            sb_issue_s;
  logic                       issue_s;
  logic                       push_s;
  logic                       pop_s;
  logic                       fifo_empty_s;
  logic [INFLIGHT_W-1:0]      inflight_s;
  logic [RD_FIFO_CW-1:0]      fifo_count_s;
  logic [FW-1:0]              fifo_wdata_s;
  logic [FW-1:0]              fifo_rdata_s;
`ifdef MEM_RD_EOL_EN
  logic [LW-1:0]              col_r;
`endif

  // Credit check and marker generation for the address currently on o_raddr
  always_comb begin
    inflight_s = INFLIGHT_W'($countones(v_r));
    issue_s    = (state_r == READ) && credit_ok(fifo_count_s, inflight_s);
    sb_issue_s = '0;
    sb_issue_s[SB_SOF] = (raddr_r == '0);
    sb_issue_s[SB_EOF] = (raddr_r == LAST_ADDR);
`ifdef MEM_RD_EOL_EN
    sb_issue_s[SB_EOL] = (col_r == LAST_COL);
`endif
  end

  // Word returns on i_rdata exactly when the oldest tracking stage is set
  assign push_s       = v_r[BRAM_RD_LATENCY-1];
  assign fifo_wdata_s = {sb_r[BRAM_RD_LATENCY-1], i_rdata};
  assign pop_s        = o_valid && i_ready;

  // Latency tracking: issue flags and their markers follow the BRAM pipeline
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v_r <= '0;
      for (int i = 0; i < BRAM_RD_LATENCY; i++) begin
        sb_r[i] <= '0;
      end
    end else begin
      v_r     <= {v_r[BRAM_RD_LATENCY-2:0], issue_s};
      sb_r[0] <= sb_issue_s;
      for (int i = 1; i < BRAM_RD_LATENCY; i++) begin
        sb_r[i] <= sb_r[i-1];
      end
    end
  end

  // Frame sequencing: state, address sweep, busy/done pulse and line position
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= IDLE;
      raddr_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef MEM_RD_EOL_EN
      col_r   <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (i_start) begin
            state_r <= READ;
            busy_r  <= 1'b1;
            raddr_r <= '0;
`ifdef MEM_RD_EOL_EN
            col_r   <= '0;
`endif
          end
        end
        READ: begin
          if (issue_s) begin
            raddr_r <= raddr_r + AW'(1);
`ifdef MEM_RD_EOL_EN
            col_r   <= (col_r == LAST_COL) ? '0 : col_r + LW'(1);
`endif
            if (raddr_r == LAST_ADDR) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (fifo_empty_s && (inflight_s == '0)) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            raddr_r <= '0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          raddr_r <= '0;
        end
      endcase
    end
  end

  mem_rd_fifo #(
    .WIDTH (FW),
    .DEPTH (RD_FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push_s),
    .i_wdata (fifo_wdata_s),
    .i_pop   (pop_s),
    .o_rdata (fifo_rdata_s),
    .o_empty (fifo_empty_s),
    .o_count (fifo_count_s)
  );

  assign o_raddr = raddr_r;
  assign o_busy  = busy_r;
  assign o_done  = done_r;
  assign o_valid = !fifo_empty_s;
  assign o_data  = fifo_rdata_s[DATA_WIDTH-1:0];
  assign o_sof   = fifo_rdata_s[DATA_WIDTH + SB_SOF];
  assign o_eof   = fifo_rdata_s[DATA_WIDTH + SB_EOF];
`ifdef MEM_RD_EOL_EN
  assign o_eol   = fifo_rdata_s[DATA_WIDTH + SB_EOL];
`endif

endmodule

// File: tb/tb_mem_rd_stream.sv
// tb_mem_rd_stream: directed bench for mem_rd_stream with DEPTH=16,
// LINE_PIXELS=4 and a 2-cycle BRAM model preloaded with mem[a]=a.
// Define MEM_RD_EOL_EN to also check o_eol.
module tb_mem_rd_stream;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic        i_ready;
  logic        o_busy;
  logic        o_done;
  logic [3:0]  o_raddr;
  logic [11:0] i_rdata;
  logic [11:0] o_data;
  logic        o_valid;
  logic        o_sof;
  logic        o_eof;
`ifdef MEM_RD_EOL_EN
  logic        o_eol;
`endif

  int vectors;
  int miscompares;

  logic [11:0] mem [16];
  logic [3:0]  addr_q;

  mem_rd_stream #(
    .DATA_WIDTH  (12),
    .DEPTH       (16),
    .LINE_PIXELS (4)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_raddr (o_raddr),
    .i_rdata (i_rdata),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sof   (o_sof),
    .o_eof   (o_eof)
`ifdef MEM_RD_EOL_EN
    ,
    .o_eol   (o_eol)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 12'(i);
  end

  // BRAM model: address register, then output register
  always @(posedge i_clk) begin
    addr_q  <= o_raddr;
    i_rdata <= mem[addr_q];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // Pulse i_start for one edge; returns at the negedge after that edge
  task automatic start_frame();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Expect consecutive beats first..last with i_ready high; optional start pulse
  task automatic stream_beats(input int first, input int last, input int pulse_at);
    for (int i = first; i <= last; i++) begin
      i_start = (i == pulse_at);
      chk("beat_valid", 32'(o_valid), 32'd1);
      chk("beat_data", 32'(o_data), 32'(i));
      chk("beat_sof", 32'(o_sof), 32'(i == 0));
      chk("beat_eof", 32'(o_eof), 32'(i == 15));
`ifdef MEM_RD_EOL_EN
      chk("beat_eol", 32'(o_eol), 32'((i % 4) == 3));
`endif
      tick();
    end
    i_start = 1'b0;
  endtask

  // After the eof handshake: one idle edge, then a single o_done pulse
  task automatic finish_frame();
    chk("tail_valid", 32'(o_valid), 32'd0);
    chk("tail_done_early", 32'(o_done), 32'd0);
    chk("tail_busy", 32'(o_busy), 32'd1);
    tick();
    chk("done_pulse", 32'(o_done), 32'd1);
    chk("done_busy", 32'(o_busy), 32'd0);
    tick();
    chk("done_clear", 32'(o_done), 32'd0);
  endtask

  task automatic check_latency();
    chk("lat_busy", 32'(o_busy), 32'd1);
    chk("lat_raddr0", 32'(o_raddr), 32'd0);
    chk("lat_valid_e0", 32'(o_valid), 32'd0);
    tick();
    chk("lat_valid_e1", 32'(o_valid), 32'd0);
    tick();
    chk("lat_valid_e2", 32'(o_valid), 32'd0);
    tick();
  endtask

  initial begin
    int exp_idx;
    int issued;
    int popped;
    logic [3:0]  prev_raddr;
    logic        pv;
    logic        pr;
    logic [11:0] pd;
    logic        ps;
    logic        pe;
    logic        got_done;

    vectors     = 0;
    miscompares = 0;
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);

    // Reset state
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_raddr", 32'(o_raddr), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_sof", 32'(o_sof), 32'd0);
    chk("rst_eof", 32'(o_eof), 32'd0);
    i_rst = 1'b0;
    tick();

    // Unthrottled frame: 3-cycle latency, 16 back-to-back beats, done
    start_frame();
    check_latency();
    stream_beats(0, 15, -1);
    finish_frame();
    repeat (3) tick();

    // Random back-pressure, about 30% ready
    start_frame();
    exp_idx = 0; issued = 0; popped = 0; prev_raddr = o_raddr;
    pv = 1'b0; pr = 1'b0; pd = '0; ps = 1'b0; pe = 1'b0; got_done = 1'b0;
    for (int c = 0; c < 2000 && !got_done; c++) begin
      if (o_raddr != prev_raddr) issued++;
      prev_raddr = o_raddr;
      if (pv && pr) popped++;
      chk("bp_credit", 32'((issued - popped) <= 8), 32'd1);
      if (pv && !pr) begin
        chk("bp_stall_valid", 32'(o_valid), 32'd1);
        chk("bp_stall_data", 32'(o_data), 32'(pd));
        chk("bp_stall_sof", 32'(o_sof), 32'(ps));
        chk("bp_stall_eof", 32'(o_eof), 32'(pe));
      end
      if (o_done) got_done = 1'b1;
      i_ready = ($urandom_range(0, 9) < 3);
      if (o_valid && i_ready) begin
        chk("bp_data", 32'(o_data), 32'(exp_idx));
        chk("bp_sof", 32'(o_sof), 32'(exp_idx == 0));
        chk("bp_eof", 32'(o_eof), 32'(exp_idx == 15));
        exp_idx++;
      end
      pv = o_valid; pr = i_ready; pd = o_data; ps = o_sof; pe = o_eof;
      tick();
    end
    chk("bp_word_count", 32'(exp_idx), 32'd16);
    chk("bp_done_seen", 32'(got_done), 32'd1);
    i_ready = 1'b1;
    repeat (3) tick();

    // Ready held low for 20 cycles: issue stops after 8 credits
    i_ready = 1'b0;
    start_frame();
    repeat (19) tick();
    chk("hold_raddr", 32'(o_raddr), 32'd8);
    chk("hold_valid", 32'(o_valid), 32'd1);
    chk("hold_data", 32'(o_data), 32'd0);
    chk("hold_sof", 32'(o_sof), 32'd1);
    i_ready = 1'b1;
    stream_beats(0, 15, -1);
    finish_frame();
    repeat (3) tick();

    // Start pulse during an active frame is dropped
    start_frame();
    check_latency();
    stream_beats(0, 15, 5);
    finish_frame();
    for (int i = 0; i < 8; i++) begin
      chk("nostart_valid", 32'(o_valid), 32'd0);
      chk("nostart_busy", 32'(o_busy), 32'd0);
      chk("nostart_done", 32'(o_done), 32'd0);
      tick();
    end

    // Reset at pixel 7 with reads in flight
    start_frame();
    check_latency();
    stream_beats(0, 6, -1);
    chk("pre_rst_data", 32'(o_data), 32'd7);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_done", 32'(o_done), 32'd0);
    chk("mid_rst_raddr", 32'(o_raddr), 32'd0);
    chk("mid_rst_data", 32'(o_data), 32'd0);
    chk("mid_rst_sof", 32'(o_sof), 32'd0);
    chk("mid_rst_eof", 32'(o_eof), 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_valid", 32'(o_valid), 32'd0);
      chk("post_rst_busy", 32'(o_busy), 32'd0);
    end
    start_frame();
    check_latency();
    stream_beats(0, 15, -1);
    finish_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
